mod_updown_counter: RTL and testbench

- Parametrised successor to the 2-bit toggle counter: a WIDTH-bit synchronous modulo-N up/down counter.
- Adds enable, direction, synchronous clear, parallel load, terminal-count and wrap outputs.
- Used as a building block for dividers, timers and cascaded (multi-digit) counters in the logic lab designs.
- All state changes on the falling edge of clk, as in the existing flip-flop family.

---
 rtl/mod_updown_counter_if.sv | 26 ++
 rtl/mod_updown_counter.sv | 78 +++++++
 tb/tb_mod_updown_counter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mod_updown_counter_if.sv
// Bus bundle for mod_updown_counter: control inputs, count and status outputs.
// The counter side uses the slave modport. The driving side uses the master modport.
interface mod_updown_counter_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up_dn;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output clr, load, load_val, en, up_dn,
    input  q, tc, wrap
  );

  modport slave (
    input  clr, load, load_val, en, up_dn,
    output q, tc, wrap
  );

endinterface

// File: rtl/mod_updown_counter.sv
// WIDTH-bit modulo-MODULUS up/down counter with clear, load, terminal count and wrap pulse.
// State updates on the falling edge of clk. reset is asynchronous and active-low.
// Optional macro MOD_UPDOWN_COUNTER_SAT_EN: saturate at the ends instead of wrapping.
// With the macro defined, wrap is never asserted.
module mod_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input logic                  clk,
  input logic                  reset,
  mod_updown_counter_if.slave  bus
);

  if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
    $error("mod_updown_counter: need 2<=WIDTH<=16 and 2<=MODULUS<=2**WIDTH");
  end

  // MODULUS-1 always fits in WIDTH bits, even when MODULUS == 2**WIDTH.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_d, q_q;
  logic             wrap_d, wrap_q;

  // Next-state selection: clr > load > en > hold.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.clr) begin
      q_d = '0;
    end else if (bus.load) begin
      // Clamp out-of-range loads so q never holds a value >= MODULUS.
      q_d = (bus.load_val > MaxVal) ? MaxVal : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (q_q == MaxVal) begin
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
          q_d    = q_q;
`else
          q_d    = '0;
          wrap_d = 1'b1;
`endif
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (q_q == '0) begin
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
          q_d    = q_q;
`else
          q_d    = MaxVal;
          wrap_d = 1'b1;
`endif
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  // Count and wrap registers. They update on the falling edge of clk.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  // Terminal count is combinational so a cascaded stage sees it on the same edge.
  always_comb begin
    bus.q    = q_q;
    bus.wrap = wrap_q;
    bus.tc   = bus.en & ((bus.up_dn & (q_q == MaxVal)) | (~bus.up_dn & (q_q == '0)));
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter (WIDTH=4, MODULUS=10): vector table plus reset corner cases.
module tb_mod_updown_counter;

  localparam int unsigned W = 4;
  localparam int unsigned M = 10;

  logic clk = 1'b1;
  logic reset;

  mod_updown_counter_if #(.WIDTH(W)) bus ();

  mod_updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Falling edges at 5, 15, 25, ... Outputs are sampled on rising edges.
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         clr;
    logic         load;
    logic [W-1:0] lv;
    logic         en;
    logic         up;
    int           eq;   // q after the edge
    int           ew;   // wrap after the edge
    int           etc;  // tc before the edge, inputs applied
    string        name;
  } vec_t;

  typedef struct {
    int    q;
    int    w;
    string name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(int clr, int load, int lv, int en, int up,
                              int eq, int ew, int etc, string name);
    vec_t v;
    v.clr  = clr[0];
    v.load = load[0];
    v.lv   = W'(lv);
    v.en   = en[0];
    v.up   = up[0];
    v.eq   = eq;
    v.ew   = ew;
    v.etc  = etc;
    v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a rising edge. Applies one vector, checks tc, crosses one falling edge, then checks.
  task automatic drive(vec_t v);
    exp_t e;
    bus.clr      = v.clr;
    bus.load     = v.load;
    bus.load_val = v.lv;
    bus.en       = v.en;
    bus.up_dn    = v.up;
    #1;
    chk({v.name, " tc"}, int'(bus.tc), v.etc);
    sb.push_back('{q: v.eq, w: v.ew, name: v.name});
    @(negedge clk);
    @(posedge clk);
    e = sb.pop_front();
    chk({e.name, " q"}, int'(bus.q), e.q);
    chk({e.name, " wrap"}, int'(bus.wrap), e.w);
  endtask

  initial begin
    // Vector table
    add(0, 0, 0, 0, 1, 0, 0, 0, "hold0");
    add(0, 0, 0, 0, 1, 0, 0, 0, "hold1");
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
    add(0, 1, 8, 0, 1, 8, 0, 0, "load8");
    add(0, 0, 0, 1, 1, 9, 0, 0, "sat_up0");
    add(0, 0, 0, 1, 1, 9, 0, 1, "sat_up1");
    add(0, 0, 0, 1, 1, 9, 0, 1, "sat_up2");
    add(0, 0, 0, 1, 1, 9, 0, 1, "sat_up3");
    add(0, 1, 0, 0, 0, 0, 0, 0, "load0");
    add(0, 0, 0, 1, 0, 0, 0, 1, "sat_dn");
    add(0, 1, 6, 0, 1, 6, 0, 0, "load6");
`else
    for (int i = 0; i < 10; i++)
      add(0, 0, 0, 1, 1, (i + 1) % 10, int'(i == 9), int'(i == 9), "up");
    add(0, 0, 0, 0, 1, 0, 0, 0, "up_post");
    add(0, 1, 13, 0, 1, 9, 0, 0, "clamp13");
    for (int i = 0; i < 10; i++) begin
      int cur;
      cur = 9 - i;
      add(0, 0, 0, 1, 0, (cur == 0) ? 9 : cur - 1, int'(cur == 0), int'(cur == 0), "down");
    end
    add(0, 0, 0, 0, 0, 9, 0, 0, "down_post");
    add(0, 1, 10, 0, 1, 9, 0, 0, "clamp10");
    add(0, 1, 4, 0, 1, 4, 0, 0, "load4");
    add(1, 1, 7, 1, 1, 0, 0, 0, "prio_clr");
    add(0, 1, 7, 0, 1, 7, 0, 0, "prio_load");
    add(0, 1, 2, 1, 1, 2, 0, 0, "load_over_en");
    add(0, 0, 0, 1, 1, 3, 0, 0, "up_to6");
    add(0, 0, 0, 1, 1, 4, 0, 0, "up_to6");
    add(0, 0, 0, 1, 1, 5, 0, 0, "up_to6");
    add(0, 0, 0, 1, 1, 6, 0, 0, "up_to6");
`endif

    // Reset held across three falling edges, with en=1 and down so tc must read 1.
    reset        = 1'b0;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.en       = 1'b1;
    bus.up_dn    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst q", int'(bus.q), 0);
      chk("rst wrap", int'(bus.wrap), 0);
      chk("rst tc_dn", int'(bus.tc), 1);
    end
    bus.up_dn = 1'b1;
    #1;
    chk("rst tc_up", int'(bus.tc), 0);

    @(posedge clk);
    reset  = 1'b1;
    bus.en = 1'b0;

    foreach (vecs[i]) drive(vecs[i]);

    // Asynchronous reset between edges, with q=6
    reset = 1'b0;
    #1;
    chk("areset q", int'(bus.q), 0);
    chk("areset wrap", int'(bus.wrap), 0);
    @(posedge clk);
    reset = 1'b1;

`ifndef MOD_UPDOWN_COUNTER_SAT_EN
    // Asynchronous reset must also clear a pending wrap pulse.
    begin
      vec_t v;
      v = '{clr: 1'b0, load: 1'b0, lv: '0, en: 1'b1, up: 1'b0,
            eq: 9, ew: 1, etc: 1, name: "wrap_dn"};
      drive(v);
    end
    reset = 1'b0;
    #1;
    chk("areset_wrap q", int'(bus.q), 0);
    chk("areset_wrap wrap", int'(bus.wrap), 0);
    @(posedge clk);
    reset = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
